// File: rtl/core_seq_ctrl_pkg.sv
// Shared definitions for the core sequencer: state encoding, halt codes,
// reset PC default and watchdog width.
package core_seq_ctrl_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned ILEN_DEF = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
  localparam int unsigned WDOG_W = 8;
  localparam logic [WDOG_W-1:0] TIMEOUT_DEF = 8'd255;

  typedef enum logic [2:0] {
    ST_FETCH    = 3'd0,
    ST_WAIT_I   = 3'd1,
    ST_DECODE   = 3'd2,
    ST_EXEC     = 3'd3,
    ST_MEM_REQ  = 3'd4,
    ST_MEM_WAIT = 3'd5,
    ST_WB       = 3'd6,
    ST_HALT     = 3'd7
  } seq_state_t;

  typedef enum logic [1:0] {
    HALT_NONE    = 2'd0,
    HALT_EBREAK  = 2'd1,
    HALT_ILLEGAL = 2'd2,
    HALT_TIMEOUT = 2'd3
  } halt_code_t;

endpackage

// File: rtl/core_seq_wdog.sv
// Wait-cycle watchdog: counts consecutive cycles spent waiting on a memory
// handshake and flags the cycle that completes LIMIT waiting cycles.
module core_seq_wdog
  import core_seq_ctrl_pkg::*;
#(
  parameter logic [WDOG_W-1:0] LIMIT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expire
);

  logic [WDOG_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_count <= '0;
    end else if (inc) begin
      r_count <= r_count + 1'b1;
    end
  end

  // r_count holds the waiting cycles already elapsed; this one is the LIMIT-th.
  assign expire = inc && (r_count == LIMIT - 1'b1);

endmodule

// File: rtl/core_seq_ctrl.sv
// Multi-cycle core sequencer: owns PC and instruction latch, drives the fetch
// and load/store handshakes, and gates writeback/retire to the WB state.
// Handshakes: a request valid rises on entering its state and stays high,
// with address stable, until the cycle its ready is sampled high.
module core_seq_ctrl
  import core_seq_ctrl_pkg::*;
#(
  parameter int unsigned       XLEN     = XLEN_DEF,
  parameter int unsigned       ILEN     = ILEN_DEF,
  parameter logic [XLEN-1:0]   RESET_PC = RESET_PC_DEF,
  parameter logic [WDOG_W-1:0] TIMEOUT  = TIMEOUT_DEF
) (
  input  logic            clk,
  input  logic            rst,
  output logic            ifu_req_valid,
  input  logic            ifu_req_ready,
  output logic [XLEN-1:0] ifu_addr,
  input  logic            ifu_rsp_valid,
  input  logic [ILEN-1:0] ifu_rsp_inst,
  output logic [ILEN-1:0] inst,
  input  logic            is_mem,
  input  logic            is_ebreak,
  input  logic            illegal,
  output logic            lsu_req_valid,
  input  logic            lsu_req_ready,
  input  logic            lsu_rsp_valid,
  input  logic [XLEN-1:0] next_pc,
  input  logic            rf_wr_req,
  output logic            rf_wr_en,
  output logic [XLEN-1:0] pc,
  output logic            retire,
  output logic            halted,
  output logic [1:0]      halt_code,
  output seq_state_t      dbg_state
);

  seq_state_t      r_state;
  logic [XLEN-1:0] r_pc;
  logic [ILEN-1:0] r_inst;
  logic            r_halted;
  halt_code_t      r_halt_code;

  logic w_awaited;
  logic w_wait_state;
  logic w_inc;
  logic w_expire;

  always_comb begin
    w_awaited    = 1'b1;
    w_wait_state = 1'b1;
    unique case (r_state)
      ST_FETCH:    w_awaited = ifu_req_ready;
      ST_WAIT_I:   w_awaited = ifu_rsp_valid;
      ST_MEM_REQ:  w_awaited = lsu_req_ready;
      ST_MEM_WAIT: w_awaited = lsu_rsp_valid;
      default:     w_wait_state = 1'b0;
    endcase
  end

  // Counter runs only while stalled; any progress or non-wait state clears it.
  assign w_inc = w_wait_state && !w_awaited;

  core_seq_wdog #(
    .LIMIT(TIMEOUT)
  ) u_wdog (
    .clk   (clk),
    .rst   (rst),
    .clr   (!w_inc),
    .inc   (w_inc),
    .expire(w_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_FETCH;
      r_pc        <= RESET_PC;
      r_inst      <= '0;
      r_halted    <= 1'b0;
      r_halt_code <= HALT_NONE;
    end else begin
      unique case (r_state)
        ST_FETCH: begin
          if (ifu_req_ready) begin
            r_state <= ST_WAIT_I;
          end else if (w_expire) begin
            r_state     <= ST_HALT;
            r_halted    <= 1'b1;
            r_halt_code <= HALT_TIMEOUT;
          end
        end
        ST_WAIT_I: begin
          if (ifu_rsp_valid) begin
            r_inst  <= ifu_rsp_inst;
            r_state <= ST_DECODE;
          end else if (w_expire) begin
            r_state     <= ST_HALT;
            r_halted    <= 1'b1;
            r_halt_code <= HALT_TIMEOUT;
          end
        end
        ST_DECODE: begin
          if (illegal) begin
            r_state     <= ST_HALT;
            r_halted    <= 1'b1;
            r_halt_code <= HALT_ILLEGAL;
          end else if (is_ebreak) begin
            r_state     <= ST_HALT;
            r_halted    <= 1'b1;
            r_halt_code <= HALT_EBREAK;
          end else begin
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (next_pc[1:0] != 2'b00) begin
            r_state     <= ST_HALT;
            r_halted    <= 1'b1;
            r_halt_code <= HALT_ILLEGAL;
          end else if (is_mem) begin
            r_state <= ST_MEM_REQ;
          end else begin
            r_state <= ST_WB;
          end
        end
        ST_MEM_REQ: begin
          if (lsu_req_ready) begin
            r_state <= ST_MEM_WAIT;
          end else if (w_expire) begin
            r_state     <= ST_HALT;
            r_halted    <= 1'b1;
            r_halt_code <= HALT_TIMEOUT;
          end
        end
        ST_MEM_WAIT: begin
          if (lsu_rsp_valid) begin
            r_state <= ST_WB;
          end else if (w_expire) begin
            r_state     <= ST_HALT;
            r_halted    <= 1'b1;
            r_halt_code <= HALT_TIMEOUT;
          end
        end
        ST_WB: begin
          r_pc    <= next_pc;
          r_state <= ST_FETCH;
        end
        ST_HALT: begin
          r_state <= ST_HALT;
        end
      endcase
    end
  end

  // Strobes are gated by rst so nothing is requested or committed in reset cycles.
  assign ifu_req_valid = (r_state == ST_FETCH) && !rst;
  assign lsu_req_valid = (r_state == ST_MEM_REQ) && !rst;
  assign rf_wr_en      = (r_state == ST_WB) && rf_wr_req && !rst;
  assign retire        = (r_state == ST_WB) && !rst;
  assign ifu_addr      = r_pc;
  assign pc            = r_pc;
  assign inst          = r_inst;
  assign halted        = r_halted;
  assign halt_code     = r_halt_code;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Directed bench for core_seq_ctrl: sequencing, stalls, memory ops, faults,
// watchdog boundary and mid-transaction reset.
module tb_core_seq_ctrl;
  import core_seq_ctrl_pkg::*;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ifu_req_ready, ifu_rsp_valid;
  logic [31:0] ifu_rsp_inst;
  logic        is_mem, is_ebreak, illegal;
  logic        lsu_req_ready, lsu_rsp_valid;
  logic [31:0] next_pc;
  logic        rf_wr_req;

  logic        ifu_req_valid, lsu_req_valid, rf_wr_en, retire, halted;
  logic [31:0] ifu_addr, inst, pc;
  logic [1:0]  halt_code;
  seq_state_t  dbg_state;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_pc;

  always #5 clk = ~clk;

  core_seq_ctrl dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
    .ifu_addr(ifu_addr), .ifu_rsp_valid(ifu_rsp_valid),
    .ifu_rsp_inst(ifu_rsp_inst), .inst(inst),
    .is_mem(is_mem), .is_ebreak(is_ebreak), .illegal(illegal),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
    .lsu_rsp_valid(lsu_rsp_valid), .next_pc(next_pc),
    .rf_wr_req(rf_wr_req), .rf_wr_en(rf_wr_en), .pc(pc),
    .retire(retire), .halted(halted), .halt_code(halt_code),
    .dbg_state(dbg_state)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    ifu_req_ready = 0; ifu_rsp_valid = 0; ifu_rsp_inst = '0;
    is_mem = 0; is_ebreak = 0; illegal = 0;
    lsu_req_ready = 0; lsu_rsp_valid = 0; next_pc = '0; rf_wr_req = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    step();
    step();
    rst = 1'b0;
    exp_pc = RST_PC;
    #1;
  endtask

  // Drives n plain ALU instructions of 5 cycles each, tracking exp_pc.
  task automatic run_plain(input int n, output int retires);
    retires = 0;
    ifu_req_ready = 1; ifu_rsp_valid = 1; rf_wr_req = 1;
    is_mem = 0; is_ebreak = 0; illegal = 0;
    for (int i = 0; i < n; i++) begin
      next_pc = exp_pc + 32'd4;
      for (int c = 0; c < 5; c++) begin
        if (retire) retires++;
        step();
      end
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    rf_wr_req = 1'b1;
    step();
    step();
    checks++; if (ifu_req_valid !== 1'b0) begin errors++; $display("FAIL rst_ifu_valid: got %b expected 0", ifu_req_valid); end
    checks++; if (ifu_addr !== RST_PC) begin errors++; $display("FAIL rst_ifu_addr: got %h expected %h", ifu_addr, RST_PC); end
    checks++; if (pc !== RST_PC) begin errors++; $display("FAIL rst_pc: got %h expected %h", pc, RST_PC); end
    checks++; if (inst !== 32'h0) begin errors++; $display("FAIL rst_inst: got %h expected 0", inst); end
    checks++; if ({lsu_req_valid, rf_wr_en, retire, halted} !== 4'b0000) begin errors++; $display("FAIL rst_strobes: got %b expected 0000", {lsu_req_valid, rf_wr_en, retire, halted}); end
    checks++; if (halt_code !== 2'd0) begin errors++; $display("FAIL rst_halt_code: got %0d expected 0", halt_code); end
    checks++; if (dbg_state !== ST_FETCH) begin errors++; $display("FAIL rst_state: got %0d expected %0d", dbg_state, ST_FETCH); end
    rst = 1'b0;
    #1;
    checks++; if (ifu_req_valid !== 1'b1) begin errors++; $display("FAIL post_rst_fetch: got %b expected 1", ifu_req_valid); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    ifu_req_ready = 1; ifu_rsp_valid = 1; rf_wr_req = 1;
    for (int i = 0; i < 3; i++) begin
      next_pc = exp_pc + 32'd4;
      ifu_rsp_inst = 32'hA000_0000 + i;
      for (int c = 0; c < 5; c++) begin
        if (c == 0) begin
          checks++; if (ifu_req_valid !== 1'b1 || ifu_addr !== exp_pc) begin errors++; $display("FAIL b2b_fetch: got valid=%b addr=%h expected valid=1 addr=%h", ifu_req_valid, ifu_addr, exp_pc); end
        end
        if (c == 2) begin
          checks++; if (inst !== 32'hA000_0000 + i) begin errors++; $display("FAIL b2b_inst: got %h expected %h", inst, 32'hA000_0000 + i); end
        end
        checks++; if (retire !== (c == 4) || rf_wr_en !== (c == 4)) begin errors++; $display("FAIL b2b_retire_slot: got retire=%b wr=%b expected %b at cycle %0d", retire, rf_wr_en, (c == 4), c); end
        step();
      end
      exp_pc = exp_pc + 32'd4;
    end
    checks++; if (ifu_req_valid !== 1'b1 || ifu_addr !== 32'h8000_000C) begin errors++; $display("FAIL b2b_fourth_fetch: got valid=%b addr=%h expected 1 8000000c", ifu_req_valid, ifu_addr); end
  endtask

  task automatic test_fetch_stall();
    do_reset();
    ifu_req_ready = 0; ifu_rsp_valid = 1; ifu_rsp_inst = 32'hDEAD_BEEF;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) ifu_req_ready = 1;
      checks++; if (ifu_req_valid !== 1'b1 || ifu_addr !== RST_PC) begin errors++; $display("FAIL stall_hold: got valid=%b addr=%h expected 1 %h at cycle %0d", ifu_req_valid, ifu_addr, RST_PC, c); end
      checks++; if (inst !== 32'h0) begin errors++; $display("FAIL stall_inst_early: got %h expected 0", inst); end
      step();
    end
    ifu_rsp_inst = 32'h1234_5678;
    checks++; if (ifu_req_valid !== 1'b0) begin errors++; $display("FAIL stall_valid_drop: got %b expected 0", ifu_req_valid); end
    step();
    checks++; if (inst !== 32'h1234_5678) begin errors++; $display("FAIL stall_inst_latch: got %h expected 12345678", inst); end
  endtask

  task automatic test_mem();
    int lsu_cnt = 0;
    int ret_cnt = 0;
    int ret_cyc = -1;
    do_reset();
    ifu_req_ready = 1; ifu_rsp_valid = 1; is_mem = 1; rf_wr_req = 1;
    next_pc = RST_PC + 32'd4;
    for (int c = 0; c < 14; c++) begin
      lsu_req_ready = (c == 6);
      lsu_rsp_valid = (c == 6) || (c == 11);
      if (lsu_req_valid) lsu_cnt++;
      if (retire) begin ret_cnt++; ret_cyc = c; end
      if (c == 7) begin
        checks++; if (dbg_state !== ST_MEM_WAIT) begin errors++; $display("FAIL mem_accept_rsp_ignored: got state %0d expected %0d", dbg_state, ST_MEM_WAIT); end
      end
      if (c == 13) begin
        checks++; if (ifu_req_valid !== 1'b1 || ifu_addr !== RST_PC + 32'd4) begin errors++; $display("FAIL mem_next_fetch: got valid=%b addr=%h expected 1 %h", ifu_req_valid, ifu_addr, RST_PC + 32'd4); end
      end
      step();
    end
    checks++; if (lsu_cnt !== 3) begin errors++; $display("FAIL mem_req_cycles: got %0d expected 3", lsu_cnt); end
    checks++; if (ret_cnt !== 1 || ret_cyc !== 12) begin errors++; $display("FAIL mem_retire: got count=%0d cycle=%0d expected 1 at 12", ret_cnt, ret_cyc); end
  endtask

  task automatic test_ebreak();
    int r;
    int ret_cnt = 0;
    int wr_cnt = 0;
    do_reset();
    run_plain(3, r);
    checks++; if (r !== 3) begin errors++; $display("FAIL ebreak_prefix_retires: got %0d expected 3", r); end
    is_ebreak = 1;
    next_pc = exp_pc + 32'd4;
    for (int c = 0; c < 10; c++) begin
      if (c == 0) begin
        checks++; if (ifu_addr !== 32'h8000_000C) begin errors++; $display("FAIL ebreak_fetch_addr: got %h expected 8000000c", ifu_addr); end
      end
      if (retire) ret_cnt++;
      if (rf_wr_en) wr_cnt++;
      step();
    end
    checks++; if (halted !== 1'b1 || halt_code !== 2'd1) begin errors++; $display("FAIL ebreak_halt: got halted=%b code=%0d expected 1 1", halted, halt_code); end
    checks++; if (pc !== 32'h8000_000C) begin errors++; $display("FAIL ebreak_pc: got %h expected 8000000c", pc); end
    checks++; if (ret_cnt !== 0 || wr_cnt !== 0) begin errors++; $display("FAIL ebreak_no_commit: got retire=%0d wr=%0d expected 0 0", ret_cnt, wr_cnt); end
    checks++; if (ifu_req_valid !== 1'b0 || lsu_req_valid !== 1'b0) begin errors++; $display("FAIL ebreak_no_req: got ifu=%b lsu=%b expected 0 0", ifu_req_valid, lsu_req_valid); end
  endtask

  task automatic test_misaligned();
    int ret_cnt = 0;
    do_reset();
    ifu_req_ready = 1; ifu_rsp_valid = 1; rf_wr_req = 1;
    next_pc = 32'h8000_0002;
    for (int c = 0; c < 8; c++) begin
      if (retire) ret_cnt++;
      step();
    end
    checks++; if (halted !== 1'b1 || halt_code !== 2'd2) begin errors++; $display("FAIL misalign_halt: got halted=%b code=%0d expected 1 2", halted, halt_code); end
    checks++; if (pc !== RST_PC || ret_cnt !== 0) begin errors++; $display("FAIL misalign_pc: got pc=%h retires=%0d expected %h 0", pc, ret_cnt, RST_PC); end
  endtask

  task automatic test_illegal_priority();
    do_reset();
    ifu_req_ready = 1; ifu_rsp_valid = 1; illegal = 1; is_ebreak = 1;
    next_pc = RST_PC + 32'd4;
    repeat (6) step();
    checks++; if (dbg_state !== ST_HALT || halt_code !== 2'd2) begin errors++; $display("FAIL illegal_priority: got state=%0d code=%0d expected %0d 2", dbg_state, halt_code, ST_HALT); end
  endtask

  task automatic test_timeout();
    // Response in the 255th waiting cycle is still accepted.
    do_reset();
    ifu_req_ready = 1; ifu_rsp_valid = 0; ifu_rsp_inst = 32'h0BAD_F00D;
    repeat (255) step();
    ifu_rsp_valid = 1;
    step();
    checks++; if (halted !== 1'b0 || inst !== 32'h0BAD_F00D) begin errors++; $display("FAIL timeout_edge_ok: got halted=%b inst=%h expected 0 0badf00d", halted, inst); end
    // 255 empty waiting cycles expire; a response one cycle later is too late.
    do_reset();
    ifu_req_ready = 1; ifu_rsp_valid = 0; ifu_rsp_inst = 32'h0BAD_F00D;
    repeat (255) step();
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL timeout_early: got halted=%b expected 0", halted); end
    step();
    ifu_rsp_valid = 1;
    checks++; if (halted !== 1'b1 || halt_code !== 2'd3) begin errors++; $display("FAIL timeout_halt: got halted=%b code=%0d expected 1 3", halted, halt_code); end
    step();
    checks++; if (halted !== 1'b1 || inst !== 32'h0) begin errors++; $display("FAIL timeout_late_rsp: got halted=%b inst=%h expected 1 0", halted, inst); end
  endtask

  task automatic test_rst_mid();
    int r;
    do_reset();
    run_plain(1, r);
    is_mem = 1; lsu_req_ready = 1; lsu_rsp_valid = 0;
    next_pc = exp_pc + 32'd4;
    repeat (5) step();
    checks++; if (dbg_state !== ST_MEM_WAIT || pc !== RST_PC + 32'd4) begin errors++; $display("FAIL rstmid_setup: got state=%0d pc=%h expected %0d %h", dbg_state, pc, ST_MEM_WAIT, RST_PC + 32'd4); end
    rst = 1; lsu_rsp_valid = 1;
    step();
    checks++; if ({ifu_req_valid, lsu_req_valid, rf_wr_en, retire, halted} !== 5'b0) begin errors++; $display("FAIL rstmid_strobes: got %b expected 00000", {ifu_req_valid, lsu_req_valid, rf_wr_en, retire, halted}); end
    checks++; if (pc !== RST_PC || inst !== 32'h0 || halt_code !== 2'd0) begin errors++; $display("FAIL rstmid_regs: got pc=%h inst=%h code=%0d expected %h 0 0", pc, inst, halt_code, RST_PC); end
    rst = 0;
    #1;
    checks++; if (ifu_req_valid !== 1'b1 || ifu_addr !== RST_PC) begin errors++; $display("FAIL rstmid_refetch: got valid=%b addr=%h expected 1 %h", ifu_req_valid, ifu_addr, RST_PC); end
    step();
    checks++; if (dbg_state !== ST_WAIT_I || retire !== 1'b0) begin errors++; $display("FAIL rstmid_stale_rsp: got state=%0d retire=%b expected %0d 0", dbg_state, retire, ST_WAIT_I); end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_back_to_back();
    test_fetch_stall();
    test_mem();
    test_ebreak();
    test_misaligned();
    test_illegal_priority();
    test_timeout();
    test_rst_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL sim_time_limit: got timeout expected completion");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/core_seq_ctrl.md
# core_seq_ctrl

Multi-cycle sequencer for the core datapath (PC register, register file, IDU, EXU). It owns the PC and the instruction latch, drives the instruction-fetch and load/store handshakes, and gates register-file writeback to exactly one cycle per instruction. It sits between the memory-side interfaces and the decode/execute units, replacing free-running per-cycle PC increment with handshake-driven, fault-checked instruction sequencing.

## Interface
- XLEN, 32, data/address width
- ILEN, 32, instruction width
- RESET_PC, 32'h8000_0000, PC after reset
- TIMEOUT, 255, max wait cycles for any memory response (8-bit counter)

- clk  in  1  core clock
- rst  in  1  reset, synchronous, active-high
- ifu_req_valid  out  1  fetch request
- ifu_req_ready  in  1  fetch request accepted
- ifu_addr  out  XLEN  fetch address (= pc)
- ifu_rsp_valid  in  1  fetch data valid
- ifu_rsp_inst  in  ILEN  fetched instruction
- inst  out  ILEN  latched instruction to IDU
- is_mem  in  1  decoded load/store (IDU)
- is_ebreak  in  1  decoded ebreak (IDU)
- illegal  in  1  undecodable instruction (IDU)
- lsu_req_valid  out  1  load/store request
- lsu_req_ready  in  1  LSU accepted request
- lsu_rsp_valid  in  1  LSU done
- next_pc  in  XLEN  EXU next PC (pc+4 or target)
- rf_wr_req  in  1  EXU dst_valid
- rf_wr_en  out  1  register-file write enable
- pc  out  XLEN  current PC
- retire  out  1  one-cycle pulse per committed instruction
- halted  out  1  core stopped
- halt_code  out  2  0 none, 1 ebreak, 2 illegal/misaligned, 3 timeout

## Operation
- States: FETCH, WAIT_I, DECODE, EXEC, MEM_REQ, MEM_WAIT, WB, HALT.
- FETCH: ifu_req_valid=1, ifu_addr=pc held stable; valid&ready -> WAIT_I. Valid never drops before ready.
- WAIT_I: ifu_rsp_valid=1 -> inst<=ifu_rsp_inst, -> DECODE. Responses outside WAIT_I ignored.
- DECODE: illegal -> HALT code 2; else is_ebreak -> HALT code 1; else -> EXEC. illegal has priority over is_ebreak.
- EXEC: next_pc[1:0]!=0 -> HALT code 2; else is_mem -> MEM_REQ, else -> WB.
- MEM_REQ: lsu_req_valid=1 until lsu_req_ready, -> MEM_WAIT (lsu_rsp_valid in the same accept cycle is ignored).
- MEM_WAIT: lsu_rsp_valid -> WB.
- WB: rf_wr_en=rf_wr_req, pc<=next_pc, retire=1, -> FETCH.
- HALT: terminal until rst; halted=1, halt_code held, all requests and rf_wr_en 0, pc frozen at faulting instruction.
- Timeout: counter cleared on entering FETCH, WAIT_I, MEM_REQ, MEM_WAIT; increments each cycle while the awaited signal is low; reaching TIMEOUT -> HALT code 3.
- inst held constant from DECODE through WB.

## Timing
- Reset values: state FETCH (entered cycle after rst drops), pc=ifu_addr=RESET_PC, inst=0, all valids/enables/retire/halted 0, halt_code 0, counter 0.
- Requests not asserted during rst cycles.
- Minimum non-memory instruction: 5 cycles (FETCH, WAIT_I, DECODE, EXEC, WB) with ready/rsp high on entry; memory instruction min 7.
- rf_wr_en and retire high exactly one cycle per instruction, in WB only.
- pc changes only on the clk edge ending WB; next fetch issues with new pc the following cycle.
- rst mid-transaction aborts immediately; outstanding fetch/LSU responses after reset are ignored until the new request handshake.
- Timeout at exactly TIMEOUT waiting cycles: the response arriving in cycle TIMEOUT+1 is too late.

## Structure
- Shared package: state encoding, halt codes (HALT_NONE/EBREAK/ILLEGAL/TIMEOUT), RESET_PC default, TIMEOUT width.
- One sub-module: core_seq_wdog (8-bit clear/increment/expire counter).
- FSM, PC, inst latch in the top module.

## Test plan
- Reset, ready/rsp always 1, next_pc=pc+4, rf_wr_req=1 -> ifu_addr 0x80000000, 0x80000004, 0x80000008 on fetches 5 cycles apart; one retire and one rf_wr_en per instruction.
- ifu_req_ready low 3 cycles -> ifu_req_valid and ifu_addr stable for 4 cycles; inst latched only from WAIT_I response.
- is_mem=1, lsu_req_ready delayed 2, lsu_rsp_valid delayed 4 -> WB exactly once after rsp, pc advances by 4.
- is_ebreak=1 at pc 0x8000000C -> halted=1, halt_code=1, pc stays 0x8000000C, no retire, no rf_wr_en.
- next_pc=0x80000002 -> halt_code=2; ifu_rsp_valid never asserted -> halt_code=3 after 255 wait cycles.
- rst asserted in MEM_WAIT -> next cycle all outputs at reset values; first post-reset fetch at 0x80000000.
